// File: rtl/qmm_seq_ctrl.sv
// Sequencing controller for the quantized matrix-vector datapath: streams buffer reads,
// steers MAC clear/enable and the dequant strobe, then hands NUM_OUT lanes to the sink.
module qmm_seq_ctrl #(
  parameter  int VEC_LEN  = 8,
  parameter  int NUM_OUT  = 4,
  parameter  int ADDR_W   = 4,
  parameter  int PIPE_LAT = 2,
  localparam int IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic              scale_en_o,
  output logic              out_valid_o,
  output logic [IDX_W-1:0]  out_idx_o,
  input  logic              out_ready_i,
  output logic              done_o,
  output logic [2:0]        dbg_state_o
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int CNT_W = (LEN_W > $clog2(PIPE_LAT + 1)) ? LEN_W : $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_SCALE = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [PIPE_LAT-1:0] acc_pipe;

  logic              busy_d, rd_en_d, acc_clr_d, scale_en_d, out_valid_d, done_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [IDX_W-1:0]  out_idx_d;

  // Handshake: a lane transfers on a rising edge where out_valid_o and out_ready_i are
  // both high; valid never drops and idx never moves until that transfer happens.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    idx_n   = idx;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_FETCH;
            cnt_n   = '0;
            len_n   = (len_i > LEN_W'(VEC_LEN)) ? LEN_W'(VEC_LEN) : len_i;
          end
        end
      end
      ST_FETCH: begin
        if (cnt == CNT_W'(len_q) - CNT_W'(1)) begin
          state_n = ST_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt == CNT_W'(PIPE_LAT - 1)) begin
          state_n = ST_SCALE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_SCALE: begin
        state_n = ST_OUT;
        idx_n   = '0;
      end
      ST_OUT: begin
        if (out_valid_o && out_ready_i) begin
          if (idx == IDX_W'(NUM_OUT - 1)) state_n = ST_DONE;
          else                            idx_n   = idx + IDX_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered alongside it.
    busy_d      = (state_n != ST_IDLE);
    rd_en_d     = (state_n == ST_FETCH);
    rd_addr_d   = (state_n == ST_FETCH) ? cnt_n[ADDR_W-1:0] : '0;
    acc_clr_d   = (state == ST_IDLE) && (state_n == ST_FETCH);
    scale_en_d  = (state_n == ST_SCALE);
    out_valid_d = (state_n == ST_OUT);
    out_idx_d   = (state_n == ST_OUT) ? idx_n : '0;
    done_d      = (state_n == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      len_q       <= '0;
      idx         <= '0;
      busy_o      <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      acc_clr_o   <= 1'b0;
      scale_en_o  <= 1'b0;
      out_valid_o <= 1'b0;
      out_idx_o   <= '0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      len_q       <= len_n;
      idx         <= idx_n;
      busy_o      <= busy_d;
      rd_en_o     <= rd_en_d;
      rd_addr_o   <= rd_addr_d;
      acc_clr_o   <= acc_clr_d;
      scale_en_o  <= scale_en_d;
      out_valid_o <= out_valid_d;
      out_idx_o   <= out_idx_d;
      done_o      <= done_d;
    end
  end

  // Read-to-MAC latency model: acc_en follows rd_en by PIPE_LAT cycles regardless of state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_pipe <= '0;
    end else begin
      acc_pipe[0] <= rd_en_o;
      for (int i = 1; i < PIPE_LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
    end
  end

  assign acc_en_o    = acc_pipe[PIPE_LAT-1];
  assign dbg_state_o = state;

endmodule

// File: tb/tb_qmm_seq_ctrl.sv
// Bench for qmm_seq_ctrl: per-cycle expected output vectors are queued at each start and
// popped on the falling edge of every following cycle.
module tb_qmm_seq_ctrl;

  localparam int VEC_LEN  = 8;
  localparam int NUM_OUT  = 4;
  localparam int ADDR_W   = 4;
  localparam int PIPE_LAT = 2;
  localparam int IDX_W    = 2;
  localparam int VW       = 13;

  // clock / reset block
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic              ready = 1'b1;
  logic              busy, rd_en, acc_clr, acc_en, scale_en, out_valid, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [IDX_W-1:0]  out_idx;
  logic [2:0]        dbg_state;

  qmm_seq_ctrl #(
    .VEC_LEN(VEC_LEN), .NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .len_i(len),
    .busy_o(busy), .rd_en_o(rd_en), .rd_addr_o(rd_addr), .acc_clr_o(acc_clr),
    .acc_en_o(acc_en), .scale_en_o(scale_en), .out_valid_o(out_valid),
    .out_idx_o(out_idx), .out_ready_i(ready), .done_o(done), .dbg_state_o(dbg_state)
  );

  logic [VW-1:0] obs;
  assign obs = {busy, rd_en, rd_addr, acc_clr, acc_en, scale_en, out_valid, out_idx, done};

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] e;
  int n_cmp = 0;
  int n_err = 0;

  // Reference timing: cycle t of a run (t=1 is the first cycle after start is sampled),
  // with an optional stall of 'stall' extra cycles on lane 'sidx'.
  function automatic logic [VW-1:0] model(int t, int len_req, int sidx, int stall);
    int l, o0, dn, p;
    logic b, r, c, a, s, v, d;
    logic [ADDR_W-1:0] ad;
    logic [IDX_W-1:0] ix;
    b = 0; r = 0; c = 0; a = 0; s = 0; v = 0; d = 0; ad = '0; ix = '0;
    l = (len_req > VEC_LEN) ? VEC_LEN : len_req;
    if (l == 0) begin
      if (t == 1) begin b = 1; d = 1; end
    end else begin
      o0 = l + PIPE_LAT + 2;
      dn = o0 + NUM_OUT + stall;
      b  = (t >= 1) && (t <= dn);
      r  = (t >= 1) && (t <= l);
      if (r) ad = ADDR_W'(t - 1);
      c  = (t == 1);
      a  = (t >= 1 + PIPE_LAT) && (t <= l + PIPE_LAT);
      s  = (t == l + PIPE_LAT + 1);
      v  = (t >= o0) && (t < dn);
      if (v) begin
        p = t - o0;
        if (p < sidx)               ix = IDX_W'(p);
        else if (p <= sidx + stall) ix = IDX_W'(sidx);
        else                        ix = IDX_W'(p - stall);
      end
      d  = (t == dn);
    end
    return {b, r, ad, c, a, s, v, ix, d};
  endfunction

  // driver tasks
  task automatic kick(input int l);
    @(negedge clk);
    len   = (ADDR_W+1)'(l);
    start = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== '0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h/%0d want 0/0", obs, dbg_state);
    end
    rstn = 1'b1;
    for (int t = 1; t <= 2; t++) exp_q.push_back('0);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL reset_idle cyc %0d: got %h want %h", t, obs, e); end
    end
  endtask

  task automatic test_run(input string name, input int l);
    int dones = 0;
    kick(l);
    for (int t = 1; t <= 18; t++) exp_q.push_back(model(t, l, 0, 0));
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL %s cyc %0d: got %h want %h", name, t, obs, e); end
      if (done) dones++;
    end
    n_cmp++;
    if (dones != 1) begin n_err++; $display("FAIL %s_done_count: got %0d want 1", name, dones); end
  endtask

  task automatic test_zero_len();
    kick(0);
    for (int t = 1; t <= 4; t++) exp_q.push_back(model(t, 0, 0, 0));
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL zero_len cyc %0d: got %h want %h", t, obs, e); end
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin n_err++; $display("FAIL zero_len_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    kick(8);
    for (int t = 1; t <= 21; t++) exp_q.push_back(model(t, 8, 2, 3));
    for (int t = 1; t <= 21; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL backpressure cyc %0d: got %h want %h", t, obs, e); end
      ready = !(t >= 14 && t <= 16);
      if (out_valid && ready) hs++;
    end
    ready = 1'b1;
    n_cmp++;
    if (hs != NUM_OUT) begin n_err++; $display("FAIL handshake_count: got %0d want %0d", hs, NUM_OUT); end
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    kick(8);
    for (int t = 1; t <= 17; t++) exp_q.push_back(model(t, 8, 0, 0));
    for (int t = 1; t <= 17; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL ignored_start cyc %0d: got %h want %h", t, obs, e); end
      if (done) dones++;
      if (t == 3 || t == 16) begin len = '0; start = 1'b1; end
      if (t == 17) begin len = (ADDR_W+1)'(3); start = 1'b1; end
    end
    for (int t = 1; t <= 14; t++) exp_q.push_back(model(t, 3, 0, 0));
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL restart cyc %0d: got %h want %h", t, obs, e); end
      if (done) dones++;
    end
    n_cmp++;
    if (dones != 2) begin n_err++; $display("FAIL ignored_done_count: got %0d want 2", dones); end
  endtask

  task automatic test_async_reset();
    kick(8);
    for (int t = 1; t <= 5; t++) exp_q.push_back(model(t, 8, 0, 0));
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL pre_reset cyc %0d: got %h want %h", t, obs, e); end
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h/%0d want 0/0", obs, dbg_state);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int t = 1; t <= 6; t++) exp_q.push_back('0);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL post_reset cyc %0d: got %h want %h", t, obs, e); end
    end
  endtask

  initial begin
    test_reset();
    test_run("full_run", 8);
    test_zero_len();
    test_backpressure();
    test_ignored_start();
    test_async_reset();
    test_run("clamp", 12);
    test_run("short_run", 1);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: got %0d left want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
